id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus operand-forwarding and load-use hazard logic for the 5-stage MIPS core.

---
 rtl/id_ex_operand_stage.sv | 120 ++++++++++++
 tb/tb_id_ex_operand_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core, with EX-stage operand forwarding
// from EX/MEM and MEM/WB and the load-use stall request back to decode.
module id_ex_operand_stage #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int CTRL_W  = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [DATA_W-1:0]  id_rd1,
   input  logic [DATA_W-1:0]  id_rd2,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic [RADDR_W-1:0] id_rs,
   input  logic [RADDR_W-1:0] id_rt,
   input  logic [RADDR_W-1:0] id_rd,
   input  logic [CTRL_W-1:0]  id_alu_control,
   input  logic               id_alu_src,
   input  logic               id_reg_dst,
   input  logic               id_reg_write,
   input  logic               id_mem_to_reg,
   input  logic               id_mem_write,
   input  logic               id_branch,
   input  logic               flush,
   input  logic               mem_reg_write,
   input  logic [RADDR_W-1:0] mem_write_reg,
   input  logic [DATA_W-1:0]  mem_alu_out,
   input  logic               wb_reg_write,
   input  logic [RADDR_W-1:0] wb_write_reg,
   input  logic [DATA_W-1:0]  wb_result,
   output logic               load_use_stall,
   output logic               ex_valid,
   output logic [DATA_W-1:0]  SrcA,
   output logic [DATA_W-1:0]  SrcB,
   output logic [CTRL_W-1:0]  ALUControl,
   output logic [DATA_W-1:0]  ex_write_data,
   output logic [RADDR_W-1:0] ex_write_reg,
   output logic               ex_reg_write,
   output logic               ex_mem_to_reg,
   output logic               ex_mem_write,
   output logic               ex_branch
);

   typedef struct packed {
      logic               valid;
      logic [DATA_W-1:0]  rd1;
      logic [DATA_W-1:0]  rd2;
      logic [DATA_W-1:0]  imm;
      logic [RADDR_W-1:0] rs;
      logic [RADDR_W-1:0] rt;
      logic [RADDR_W-1:0] writeReg;
      logic [CTRL_W-1:0]  aluControl;
      logic               aluSrc;
      logic               regWrite;
      logic               memToReg;
      logic               memWrite;
      logic               branch;
   } stage_t;

   stage_t            stage_q, stage_d;
   logic              captureBubble;
   logic [DATA_W-1:0] fwdA, fwdB;

   // A load in EX cannot feed its value to the instruction in ID in time.
   assign load_use_stall = stage_q.valid & stage_q.memToReg & (stage_q.writeReg != '0) & id_valid &
                           ((stage_q.writeReg == id_rs) | (stage_q.writeReg == id_rt));

   assign captureBubble = flush | load_use_stall | ~id_valid;

   always_comb begin
      stage_d = '0;
      if (!captureBubble) begin
         stage_d.valid      = 1'b1;
         stage_d.rd1        = id_rd1;
         stage_d.rd2        = id_rd2;
         stage_d.imm        = id_imm;
         stage_d.rs         = id_rs;
         stage_d.rt         = id_rt;
         stage_d.writeReg   = id_reg_dst ? id_rd : id_rt;
         stage_d.aluControl = id_alu_control;
         stage_d.aluSrc     = id_alu_src;
         stage_d.regWrite   = id_reg_write;
         stage_d.memToReg   = id_mem_to_reg;
         stage_d.memWrite   = id_mem_write;
         stage_d.branch     = id_branch;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) stage_q <= '0;
      else        stage_q <= stage_d;
   end

   // The younger producer (EX/MEM) wins; register 0 is hardwired and never forwarded.
   always_comb begin
      fwdA = stage_q.rd1;
      if (mem_reg_write && (mem_write_reg != '0) && (mem_write_reg == stage_q.rs))
         fwdA = mem_alu_out;
      else if (wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == stage_q.rs))
         fwdA = wb_result;

      fwdB = stage_q.rd2;
      if (mem_reg_write && (mem_write_reg != '0) && (mem_write_reg == stage_q.rt))
         fwdB = mem_alu_out;
      else if (wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == stage_q.rt))
         fwdB = wb_result;
   end

   assign SrcA          = fwdA;
   assign SrcB          = stage_q.aluSrc ? stage_q.imm : fwdB;
   assign ex_write_data = fwdB;
   assign ex_valid      = stage_q.valid;
   assign ALUControl    = stage_q.aluControl;
   assign ex_write_reg  = stage_q.writeReg;
   assign ex_reg_write  = stage_q.regWrite;
   assign ex_mem_to_reg = stage_q.memToReg;
   assign ex_mem_write  = stage_q.memWrite;
   assign ex_branch     = stage_q.branch;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: table of ID-stage vectors with expected EX results
// queued as a scoreboard, plus hand-written reset and forwarding sequences.
module tb_id_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_rd1, id_rd2, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [2:0]  id_alu_control;
   logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_to_reg, id_mem_write, id_branch;
   logic        flush;
   logic        mem_reg_write;
   logic [4:0]  mem_write_reg;
   logic [31:0] mem_alu_out;
   logic        wb_reg_write;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_result;
   logic        load_use_stall, ex_valid;
   logic [31:0] SrcA, SrcB, ex_write_data;
   logic [2:0]  ALUControl;
   logic [4:0]  ex_write_reg;
   logic        ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_branch;

   int testsRun = 0;
   int testsFailed = 0;

   id_ex_operand_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
      .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
      .id_mem_write(id_mem_write), .id_branch(id_branch), .flush(flush),
      .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg), .mem_alu_out(mem_alu_out),
      .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_result(wb_result),
      .load_use_stall(load_use_stall), .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB),
      .ALUControl(ALUControl), .ex_write_data(ex_write_data), .ex_write_reg(ex_write_reg),
      .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_mem_write(ex_mem_write), .ex_branch(ex_branch)
   );

   always #5 clk = ~clk;

   // ctrls/expCtrls pack {regWrite, memToReg, memWrite, branch}
   typedef struct {
      logic        valid;
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rs, rt, rd;
      logic [2:0]  ctl;
      logic        aluSrc, regDst;
      logic [3:0]  ctrls;
      logic        flush;
      logic        memRw;
      logic [4:0]  memWr;
      logic [31:0] memOut;
      logic        wbRw;
      logic [4:0]  wbWr;
      logic [31:0] wbRes;
      logic        expStall, expValid;
      logic [31:0] expA, expB, expWd;
      logic [2:0]  expCtl;
      logic [4:0]  expWreg;
      logic [3:0]  expCtrls;
   } vec_t;

   vec_t vecs[19];
   vec_t expQ[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      id_valid       = v.valid;
      id_rd1         = v.rd1;
      id_rd2         = v.rd2;
      id_imm         = v.imm;
      id_rs          = v.rs;
      id_rt          = v.rt;
      id_rd          = v.rd;
      id_alu_control = v.ctl;
      id_alu_src     = v.aluSrc;
      id_reg_dst     = v.regDst;
      {id_reg_write, id_mem_to_reg, id_mem_write, id_branch} = v.ctrls;
      flush          = v.flush;
   endtask

   task automatic driveForward(input vec_t v);
      mem_reg_write = v.memRw;
      mem_write_reg = v.memWr;
      mem_alu_out   = v.memOut;
      wb_reg_write  = v.wbRw;
      wb_write_reg  = v.wbWr;
      wb_result     = v.wbRes;
   endtask

   task automatic checkEx(input int idx, input vec_t e);
      checkOutput($sformatf("v%0d ex_valid", idx), {31'd0, ex_valid}, {31'd0, e.expValid});
      checkOutput($sformatf("v%0d SrcA", idx), SrcA, e.expA);
      checkOutput($sformatf("v%0d SrcB", idx), SrcB, e.expB);
      checkOutput($sformatf("v%0d ex_write_data", idx), ex_write_data, e.expWd);
      checkOutput($sformatf("v%0d ALUControl", idx), {29'd0, ALUControl}, {29'd0, e.expCtl});
      checkOutput($sformatf("v%0d ex_write_reg", idx), {27'd0, ex_write_reg}, {27'd0, e.expWreg});
      checkOutput($sformatf("v%0d ctrls", idx),
                  {28'd0, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_branch}, {28'd0, e.expCtrls});
   endtask

   initial begin
      // valid rd1 rd2 imm rs rt rd ctl aluSrc regDst ctrls flush | memRw memWr memOut wbRw wbWr wbRes | expStall expValid expA expB expWd expCtl expWreg expCtrls
      vecs[0]  = '{1'b1, 32'h5, 32'h7, 32'h0, 5'd1, 5'd2, 5'd3, 3'b010, 1'b0, 1'b1, 4'b1000, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b1, 32'h5, 32'h7, 32'h7, 3'b010, 5'd3, 4'b1000};
      vecs[1]  = '{1'b1, 32'h11, 32'h22, 32'h0, 5'd4, 5'd6, 5'd7, 3'b110, 1'b0, 1'b1, 4'b1000, 1'b0,
                   1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB,
                   1'b0, 1'b1, 32'hAA, 32'h22, 32'h22, 3'b110, 5'd7, 4'b1000};
      vecs[2]  = '{1'b1, 32'h11, 32'h22, 32'h0, 5'd4, 5'd6, 5'd7, 3'b110, 1'b0, 1'b1, 4'b1000, 1'b0,
                   1'b0, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB,
                   1'b0, 1'b1, 32'hBB, 32'h22, 32'h22, 3'b110, 5'd7, 4'b1000};
      vecs[3]  = '{1'b1, 32'h33, 32'h44, 32'h0, 5'd0, 5'd2, 5'd8, 3'b000, 1'b0, 1'b1, 4'b1000, 1'b0,
                   1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB,
                   1'b0, 1'b1, 32'h33, 32'h44, 32'h44, 3'b000, 5'd8, 4'b1000};
      vecs[4]  = '{1'b1, 32'h1, 32'h2, 32'h0, 5'd9, 5'd10, 5'd11, 3'b001, 1'b0, 1'b1, 4'b1001, 1'b0,
                   1'b1, 5'd10, 32'hCC, 1'b1, 5'd10, 32'hDD,
                   1'b0, 1'b1, 32'h1, 32'hCC, 32'hCC, 3'b001, 5'd11, 4'b1001};
      vecs[5]  = '{1'b1, 32'h5, 32'h99, 32'hFFFFFFFC, 5'd1, 5'd12, 5'd0, 3'b010, 1'b1, 1'b0, 4'b0010, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h10,
                   1'b0, 1'b1, 32'h5, 32'hFFFFFFFC, 32'h10, 3'b010, 5'd12, 4'b0010};
      vecs[6]  = '{1'b0, 32'h77, 32'h88, 32'h9, 5'd3, 5'd4, 5'd5, 3'b111, 1'b1, 1'b1, 4'b1010, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 4'b0000};
      vecs[7]  = '{1'b1, 32'h12, 32'h34, 32'h8, 5'd2, 5'd3, 5'd0, 3'b010, 1'b1, 1'b0, 4'b0010, 1'b1,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 4'b0000};
      vecs[8]  = '{1'b1, 32'h100, 32'h55, 32'h4, 5'd1, 5'd5, 5'd0, 3'b010, 1'b1, 1'b0, 4'b1100, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b1, 32'h100, 32'h4, 32'h55, 3'b010, 5'd5, 4'b1100};
      vecs[9]  = '{1'b1, 32'hDEAD, 32'h7, 32'h0, 5'd5, 5'd2, 5'd6, 3'b010, 1'b0, 1'b1, 4'b1000, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 4'b0000};
      vecs[10] = '{1'b1, 32'hDEAD, 32'h7, 32'h0, 5'd5, 5'd2, 5'd6, 3'b010, 1'b0, 1'b1, 4'b1000, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234,
                   1'b0, 1'b1, 32'h1234, 32'h7, 32'h7, 3'b010, 5'd6, 4'b1000};
      vecs[11] = '{1'b1, 32'h0, 32'h0, 32'h20, 5'd0, 5'd8, 5'd0, 3'b010, 1'b1, 1'b0, 4'b1100, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b1, 32'h0, 32'h20, 32'h0, 3'b010, 5'd8, 4'b1100};
      vecs[12] = '{1'b1, 32'h3, 32'h4, 32'h0, 5'd3, 5'd8, 5'd9, 3'b010, 1'b0, 1'b1, 4'b1010, 1'b1,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 4'b0000};
      vecs[13] = '{1'b1, 32'h10, 32'h0, 32'h8, 5'd1, 5'd0, 5'd0, 3'b010, 1'b1, 1'b0, 4'b1100, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b1, 32'h10, 32'h8, 32'h0, 3'b010, 5'd0, 4'b1100};
      vecs[14] = '{1'b1, 32'h3, 32'h4, 32'h0, 5'd0, 5'd0, 5'd4, 3'b010, 1'b0, 1'b1, 4'b1000, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b1, 32'h3, 32'h4, 32'h4, 3'b010, 5'd4, 4'b1000};
      vecs[15] = '{1'b1, 32'h40, 32'h0, 32'h0, 5'd2, 5'd7, 5'd0, 3'b010, 1'b1, 1'b0, 4'b1100, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 3'b010, 5'd7, 4'b1100};
      vecs[16] = '{1'b0, 32'h1, 32'h2, 32'h0, 5'd7, 5'd7, 5'd1, 3'b010, 1'b0, 1'b1, 4'b1000, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 4'b0000};
      vecs[17] = '{1'b1, 32'h8, 32'h0, 32'h4, 5'd3, 5'd9, 5'd0, 3'b010, 1'b1, 1'b0, 4'b1100, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b1, 32'h8, 32'h4, 32'h0, 3'b010, 5'd9, 4'b1100};
      vecs[18] = '{1'b1, 32'h6, 32'h7, 32'h0, 5'd1, 5'd9, 5'd10, 3'b010, 1'b0, 1'b1, 4'b1000, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 4'b0000};

      // Reset held for two edges while decode presents a valid instruction
      rst_n = 1'b0;
      applyStimulus(vecs[0]);
      driveForward(vecs[6]);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset ex_valid", {31'd0, ex_valid}, 32'd0);
      checkOutput("reset SrcA", SrcA, 32'd0);
      checkOutput("reset SrcB", SrcB, 32'd0);
      checkOutput("reset ex_write_data", ex_write_data, 32'd0);
      checkOutput("reset ALUControl", {29'd0, ALUControl}, 32'd0);
      checkOutput("reset load_use_stall", {31'd0, load_use_stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("v%0d load_use_stall", i), {31'd0, load_use_stall}, {31'd0, vecs[i].expStall});
         expQ.push_back(vecs[i]);
         @(posedge clk);
         #1;
         driveForward(vecs[i]);
         #1;
         if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL v%0d scoreboard: got empty queue, expected one entry", i);
         end else begin
            checkEx(i, expQ.pop_front());
         end
      end

      // Forwarding priority change within one EX cycle: MEM first, then WB once MEM drops out
      @(negedge clk);
      applyStimulus(vecs[1]);
      driveForward(vecs[6]);
      @(posedge clk);
      #1;
      driveForward(vecs[1]);
      #1;
      checkOutput("seq mem fwd SrcA", SrcA, 32'hAA);
      mem_reg_write = 1'b0;
      #1;
      checkOutput("seq wb fwd SrcA", SrcA, 32'hBB);

      // Reset asserted while an instruction sits in EX
      @(negedge clk);
      driveForward(vecs[6]);
      applyStimulus(vecs[0]);
      @(posedge clk);
      #1;
      checkOutput("seq pre-reset ex_valid", {31'd0, ex_valid}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("seq mid-reset ex_valid", {31'd0, ex_valid}, 32'd0);
      checkOutput("seq mid-reset ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
      checkOutput("seq mid-reset SrcA", SrcA, 32'd0);
      checkOutput("seq mid-reset ex_write_reg", {27'd0, ex_write_reg}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
